// File: rtl/video_pkg.sv
// Shared types and default geometry for the packed RGB888 video stream.
package video_pkg;

  localparam int X_SIZE_DEFAULT = 640;
  localparam int Y_SIZE_DEFAULT = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [2:0] {SYNC, W0, W1, W2, EMIT3, DROP} unpack_state_e;

endpackage

// File: rtl/pixel_unpacker_if.sv
// 32-bit packed pixel AXI-Stream bus between packer and unpacker.
interface pixel_unpacker_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// Unpacks 3 stream words into 4 RGB888 pixels, tracks x/y and checks line/frame geometry.
//
// state | meaning
// SYNC  | waiting for a tuser word to lock onto a frame
// W0    | next word carries p0 and p1.b
// W1    | next word carries p1.g/r and p2.b/g
// W2    | next word carries p2.r and all of p3
// EMIT3 | input stalled while p3 is emitted from the residue
// DROP  | overlong line; discarding words through the next tlast
module pixel_unpacker
  import video_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEFAULT,
  parameter int Y_SIZE = Y_SIZE_DEFAULT
) (
  input  logic                aclk,
  input  logic                aresetn,
  pixel_unpacker_if.slave     in_stream,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic [9:0]          x,
  output logic [8:0]          y,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_valid,
  input  logic                pix_ready,
  input  logic                err_clr,
  output logic                err_short,
  output logic                err_long,
  output logic                err_sof,
  output logic [15:0]         frame_count
);

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] X_PEN  = 10'(X_SIZE - 2);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  unpack_state_e state_q, state_d, eff;
  logic [23:0]   res_q, res_d;
  logic          drop_pend_q, drop_pend_d;
  logic [9:0]    nx_q, nx_d, x_q, x_d, cx;
  logic [8:0]    ny_q, ny_d, y_q, y_d, cy;
  logic [15:0]   fc_q, fc_d;
  rgb888_t       pix_q, pix_d, px;
  logic          pix_valid_q, pix_valid_d;
  logic          sof_q, sof_d, eol_q, eol_d;
  logic          err_short_q, err_short_d, err_long_q, err_long_d, err_sof_q, err_sof_d;
  logic          run_q, run_d;
  logic          out_free, accept, word_ok, emit, line_brk, expected;
  logic          set_short, set_long, set_sof;
  logic          unused_tkeep;

  assign unused_tkeep     = ^in_stream.tkeep;
  assign out_free         = !pix_valid_q || pix_ready;
  assign in_stream.tready = run_q && out_free && (state_q != EMIT3);
  assign accept           = in_stream.tvalid && in_stream.tready;
  assign run_d            = 1'b1;

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    drop_pend_d = drop_pend_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    fc_d        = fc_q;
    pix_valid_d = pix_valid_q;
    pix_d       = pix_q;
    x_d         = x_q;
    y_d         = y_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    set_short   = 1'b0;
    set_long    = 1'b0;
    set_sof     = 1'b0;
    word_ok     = 1'b0;
    emit        = 1'b0;
    line_brk    = 1'b0;
    expected    = 1'b0;
    eff         = state_q;
    cx          = nx_q;
    cy          = ny_q;
    px          = '0;

    if (out_free) pix_valid_d = 1'b0;

    if (accept) begin
      case (state_q)
        SYNC: begin
          if (in_stream.tuser) begin
            word_ok = 1'b1; eff = W0; cx = '0; cy = '0;
          end
        end
        DROP: begin
          if (in_stream.tuser) begin
            word_ok = 1'b1; eff = W0; cx = '0; cy = '0;
          end else if (in_stream.tlast) begin
            state_d = W0;
          end
        end
        default: begin
          word_ok = 1'b1;
          if (in_stream.tuser && !(state_q == W0 && nx_q == '0 && ny_q == '0)) begin
            set_sof = 1'b1; eff = W0; cx = '0; cy = '0;
          end
        end
      endcase
    end

    if (word_ok) begin
      expected = (eff == W2) && (cx == X_PEN);
      emit     = 1'b1;
      case (eff)
        W0: begin
          px.r = in_stream.tdata[23:16]; px.g = in_stream.tdata[15:8]; px.b = in_stream.tdata[7:0];
          res_d   = {res_q[23:8], in_stream.tdata[31:24]};
          state_d = W1;
        end
        W1: begin
          px.r = in_stream.tdata[15:8]; px.g = in_stream.tdata[7:0]; px.b = res_q[7:0];
          res_d   = {res_q[23:16], in_stream.tdata[31:16]};
          state_d = W2;
        end
        default: begin
          px.r = in_stream.tdata[7:0]; px.g = res_q[15:8]; px.b = res_q[7:0];
          res_d   = in_stream.tdata[31:8];
          state_d = EMIT3;
        end
      endcase
      // a premature tlast drops the residue, so p3 of a short word2 is never emitted
      if (in_stream.tlast && !expected) begin
        set_short = 1'b1; line_brk = 1'b1; state_d = W0;
      end else if (!in_stream.tlast && expected) begin
        set_long = 1'b1; drop_pend_d = 1'b1;
      end
    end else if (state_q == EMIT3 && out_free) begin
      emit        = 1'b1;
      px          = rgb888_t'(res_q);
      state_d     = drop_pend_q ? DROP : W0;
      drop_pend_d = 1'b0;
    end

    if (emit) begin
      pix_valid_d = 1'b1;
      pix_d       = px;
      x_d         = cx;
      y_d         = cy;
      sof_d       = (cx == '0) && (cy == '0);
      eol_d       = (cx == X_LAST);
      if (line_brk || cx == X_LAST) begin
        nx_d = '0;
        if (cy == Y_LAST) begin
          ny_d = '0;
          if (!line_brk) fc_d = fc_q + 16'd1;
        end else begin
          ny_d = cy + 9'd1;
        end
      end else begin
        nx_d = cx + 10'd1;
        ny_d = cy;
      end
    end

    err_short_d = set_short | (err_short_q & ~err_clr);
    err_long_d  = set_long  | (err_long_q  & ~err_clr);
    err_sof_d   = set_sof   | (err_sof_q   & ~err_clr);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= SYNC;
      res_q       <= '0;
      drop_pend_q <= 1'b0;
      nx_q        <= '0;
      ny_q        <= '0;
      fc_q        <= '0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_sof_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      drop_pend_q <= drop_pend_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      fc_q        <= fc_d;
      pix_valid_q <= pix_valid_d;
      pix_q       <= pix_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_sof_q   <= err_sof_d;
      run_q       <= run_d;
    end
  end

  assign r           = pix_q.r;
  assign g           = pix_q.g;
  assign b           = pix_q.b;
  assign x           = x_q;
  assign y           = y_q;
  assign pix_sof     = sof_q;
  assign pix_eol     = eol_q;
  assign pix_valid   = pix_valid_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_sof     = err_sof_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized and directed checks of pixel_unpacker against a byte-queue reference model.
module tb_pixel_unpacker;
  import video_pkg::*;

  localparam int XS = 640;
  localparam int YS = 8;

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          user;
  } word_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
  } pix_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  pixel_unpacker_if s_if();
  logic [7:0]  r, g, b;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_sof, pix_eol, pix_valid, pix_ready, err_clr;
  logic        err_short, err_long, err_sof;
  logic [15:0] frame_count;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk(aclk), .aresetn(aresetn), .in_stream(s_if),
    .r(r), .g(g), .b(b), .x(x), .y(y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_clr(err_clr), .err_short(err_short), .err_long(err_long), .err_sof(err_sof),
    .frame_count(frame_count)
  );

  word_t word_q[$];
  pix_t  exp_q[$];
  pix_t  obs_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    rdy_mode = 0;
  bit    gaps = 1'b0;
  bit    taken = 1'b0;

  // reference model state: byte queue, coordinates, mode 0=sync 1=run 2=drop
  logic [7:0] buf_q[$];
  int mx, my, mfc, mmode;
  bit m_es, m_el, m_ef;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void m_emit();
    pix_t p;
    p.b = buf_q.pop_front();
    p.g = buf_q.pop_front();
    p.r = buf_q.pop_front();
    p.x = 10'(mx);
    p.y = 9'(my);
    p.sof = (mx == 0 && my == 0);
    p.eol = (mx == XS - 1);
    exp_q.push_back(p);
    if (mx == XS - 1) begin
      mx = 0;
      if (my == YS - 1) begin my = 0; mfc = (mfc + 1) % 65536; end
      else my++;
    end else mx++;
  endfunction

  function automatic void m_word(input word_t w);
    bit restart = 1'b0;
    bit expct;
    int res_len;
    if (mmode == 0) begin
      if (!w.user) return;
      restart = 1'b1;
    end else if (mmode == 2) begin
      if (w.user) restart = 1'b1;
      else begin
        if (w.last) mmode = 1;
        return;
      end
    end else if (w.user && !(buf_q.size() == 0 && mx == 0 && my == 0)) begin
      m_ef = 1'b1;
      restart = 1'b1;
    end
    if (restart) begin buf_q.delete(); mx = 0; my = 0; mmode = 1; end
    res_len = buf_q.size();
    expct = (res_len == 2 && mx == XS - 2);
    for (int k = 0; k < 4; k++) buf_q.push_back(w.data[8*k +: 8]);
    if (w.last && !expct) begin
      m_es = 1'b1;
      m_emit();
      buf_q.delete();
      mx = 0;
      my = (my == YS - 1) ? 0 : my + 1;
    end else begin
      while (buf_q.size() >= 3) m_emit();
      if (!w.last && expct) begin m_el = 1'b1; mmode = 2; end
    end
  endfunction

  // one clock of stimulus: inputs change at negedge, handshake sampled just after
  task automatic cycle();
    @(negedge aclk);
    if (taken) begin s_if.tvalid = 1'b0; taken = 1'b0; end
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (!s_if.tvalid && word_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      s_if.tdata  = word_q[0].data;
      s_if.tlast  = word_q[0].last;
      s_if.tuser  = word_q[0].user;
      s_if.tvalid = 1'b1;
    end
    #1;
    if (s_if.tvalid && s_if.tready) begin
      m_word(word_q.pop_front());
      taken = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((word_q.size() > 0 || s_if.tvalid || exp_q.size() > 0 || pix_valid) && k < 20000) begin
      cycle();
      k++;
    end
    if (k >= 20000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain: timed out with %0d words and %0d pixels outstanding, required 0",
               name, word_q.size(), exp_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic push_word(input logic [31:0] d, input bit last, input bit user);
    word_t w;
    w.data = d; w.last = last; w.user = user;
    word_q.push_back(w);
  endtask

  task automatic push_line(input int first, input int n, input int last_at, input int user_at, input bit asc);
    for (int i = first; i < n; i++) begin
      if (asc) push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, i == last_at, i == user_at);
      else     push_word($urandom, i == last_at, i == user_at);
    end
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_err_short"}, err_short, m_es);
    chk({nm, "_err_long"},  err_long,  m_el);
    chk({nm, "_err_sof"},   err_sof,   m_ef);
    chk({nm, "_frames"},    frame_count, 16'(mfc));
  endtask

  task automatic clr_err();
    @(negedge aclk);
    err_clr = 1'b1;
    m_es = 1'b0; m_el = 1'b0; m_ef = 1'b0;
    @(negedge aclk);
    err_clr = 1'b0;
    #2;
  endtask

  // compare process: every accepted pixel against the model, plus stall behaviour
  pix_t cur, prev_pix;
  bit   prev_stall = 1'b0;
  always @(negedge aclk) begin
    #2;
    if (aresetn) begin
      cur = {r, g, b, x, y, pix_sof, pix_eol};
      if (prev_stall) chk("stall_hold", cur, prev_pix);
      if (pix_valid && !pix_ready) chk("tready_in_stall", s_if.tready, 1'b0);
      if (pix_valid && pix_ready) begin
        obs_q.push_back(cur);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_pixel: got pixel 0x%0h, expected none", cur);
        end else begin
          chk("pixel", cur, exp_q.pop_front());
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_eol;
    int kind;
    int e;
    s_if.tdata = '0; s_if.tkeep = 4'hF; s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tvalid = 1'b0;
    pix_ready = 1'b0;
    err_clr = 1'b0;
    mx = 0; my = 0; mfc = 0; mmode = 0; m_es = 0; m_el = 0; m_ef = 0;

    repeat (3) @(negedge aclk);
    #1;
    chk("rst_tready", s_if.tready, 1'b0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pixel", {r, g, b, x, y, pix_sof, pix_eol}, 43'd0);
    check_state("rst");
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // sync: three junk words, then a frame start
    obs_q.delete();
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 1'b0);
    push_word(32'h44332211, 1'b0, 1'b1);
    push_line(1, 480, 479, -1, 1'b0);
    drain("sync");
    chk("sync_count", obs_q.size(), 640);
    chk("sync_p0", obs_q[0], {8'h33, 8'h22, 8'h11, 10'd0, 9'd0, 1'b1, 1'b0});
    check_state("sync");

    // full line of ascending bytes
    obs_q.delete();
    push_line(0, 480, 479, -1, 1'b1);
    drain("full");
    n_eol = 0;
    foreach (obs_q[i]) if (obs_q[i].eol) n_eol++;
    chk("full_count", obs_q.size(), 640);
    chk("full_p1", obs_q[1], {8'h05, 8'h04, 8'h03, 10'd1, 9'd1, 1'b0, 1'b0});
    chk("full_p639", obs_q[639], {8'h7F, 8'h7E, 8'h7D, 10'd639, 9'd1, 1'b0, 1'b1});
    chk("full_eol_count", n_eol, 1);
    chk("full_flags", {err_short, err_long, err_sof}, 3'b000);

    // same line with pix_ready toggling
    obs_q.delete();
    rdy_mode = 1;
    push_line(0, 480, 479, -1, 1'b1);
    drain("bp");
    chk("bp_count", obs_q.size(), 640);
    chk("bp_p1", obs_q[1], {8'h05, 8'h04, 8'h03, 10'd1, 9'd2, 1'b0, 1'b0});
    rdy_mode = 0;

    // short line: tlast on the 299th word (word1 phase)
    obs_q.delete();
    push_line(0, 299, 298, -1, 1'b0);
    drain("short");
    chk("short_count", obs_q.size(), 398);
    chk("short_err", err_short, 1'b1);
    check_state("short");
    obs_q.delete();
    push_line(0, 480, 479, -1, 1'b0);
    drain("after_short");
    chk("after_short_xy", {obs_q[0].x, obs_q[0].y}, {10'd0, 9'd4});
    clr_err();
    chk("clr_err_short", err_short, 1'b0);

    // long line: tlast only on word 482
    obs_q.delete();
    push_line(0, 483, 482, -1, 1'b0);
    drain("long");
    chk("long_count", obs_q.size(), 640);
    chk("long_err", err_long, 1'b1);
    check_state("long");
    obs_q.delete();
    push_line(0, 480, 479, -1, 1'b0);
    push_line(0, 480, 479, -1, 1'b0);
    drain("wrap");
    chk("after_long_xy", {obs_q[0].x, obs_q[0].y}, {10'd0, 9'd6});
    chk("wrap_frames", frame_count, 16'd1);
    check_state("wrap");

    // new frame, then tuser injected at x=100 of line 1
    clr_err();
    obs_q.delete();
    push_line(0, 480, 479, 0, 1'b0);
    push_line(0, 75, -1, -1, 1'b0);
    push_line(0, 480, 479, 0, 1'b0);
    drain("midsof");
    chk("midsof_count", obs_q.size(), 1380);
    chk("midsof_restart", {obs_q[740].x, obs_q[740].y, obs_q[740].sof}, {10'd0, 9'd0, 1'b1});
    chk("midsof_err", err_sof, 1'b1);
    chk("midsof_frames", frame_count, 16'd1);
    check_state("midsof");

    // random lines with random stalls, gaps and geometry errors
    clr_err();
    rdy_mode = 2;
    gaps = 1'b1;
    for (int ln = 0; ln < 16; ln++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        e = $urandom_range(0, 478);
        push_line(0, e + 1, e, -1, 1'b0);
      end else if (kind == 1) begin
        e = $urandom_range(1, 3);
        push_line(0, 480 + e, 479 + e, -1, 1'b0);
      end else if (kind == 2) begin
        push_line(0, 480, 479, $urandom_range(1, 479), 1'b0);
      end else begin
        push_line(0, 480, 479, -1, 1'b0);
      end
      if (ln % 4 == 3) drain("rand");
    end
    drain("rand_end");
    check_state("rand");

    // reset in the middle of a line
    push_line(0, 480, 479, -1, 1'b0);
    repeat (100) cycle();
    @(negedge aclk);
    aresetn = 1'b0;
    word_q.delete();
    exp_q.delete();
    s_if.tvalid = 1'b0;
    taken = 1'b0;
    #1;
    chk("midrst_tready", s_if.tready, 1'b0);
    chk("midrst_pix_valid", pix_valid, 1'b0);
    chk("midrst_frames", frame_count, 16'd0);
    chk("midrst_flags", {err_short, err_long, err_sof}, 3'b000);
    repeat (2) @(negedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
